// File: rtl/store_commit_queue_pkg.sv
// rtl/store_commit_queue_pkg.sv - shared store encodings and queue entry type
// Holds the RISC-V store funct3 encodings and the drain-queue entry layout.
// The store buffer and the commit queue both import this package.
package store_commit_queue_pkg;

  localparam logic [2:0] FUNCT3_SB = 3'b000;
  localparam logic [2:0] FUNCT3_SH = 3'b001;
  localparam logic [2:0] FUNCT3_SW = 3'b010;

  // One queued word write, already lane-formatted.
  typedef struct packed {
    logic [29:0] word_addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] inst_num;
  } scq_entry_t;

endpackage

// File: rtl/store_commit_queue_if.sv
// rtl/store_commit_queue_if.sv - commit and data-memory handshake bundle
// Ports:
//   commit_*  retiring store from the ROB (valid/ready handshake)
//   dmem_*    word write toward data memory (req/ack handshake)
// master: ROB and memory side (the environment); slave: the queue.
interface store_commit_queue_if;

  logic        commit_valid;
  logic        commit_ready;
  logic [31:0] commit_addr;
  logic [31:0] commit_data;
  logic [2:0]  commit_funct3;
  logic [31:0] commit_inst_num;

  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;

  modport master (
    output commit_valid, commit_addr, commit_data, commit_funct3, commit_inst_num,
    input  commit_ready,
    input  dmem_req, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack
  );

  modport slave (
    input  commit_valid, commit_addr, commit_data, commit_funct3, commit_inst_num,
    output commit_ready,
    output dmem_req, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack
  );

endinterface

// File: rtl/store_commit_queue_lane_fmt.sv
// rtl/store_commit_queue_lane_fmt.sv - store lane formatter
// Combinational. Turns a byte-addressed store into word-lane data and byte
// enables, and flags misaligned or unknown-width stores.
// Ports:
//   funct3   in   store width encoding
//   addr_lo  in   byte offset within the word
//   data     in   right-justified store data
//   wdata    out  lane-replicated write data
//   be       out  byte enables
//   illegal  out  store cannot be issued as a single aligned word write
module store_lane_fmt
  import store_commit_queue_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        illegal
);

  always_comb begin
    wdata   = '0;
    be      = '0;
    illegal = 1'b0;
    case (funct3)
      FUNCT3_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
      end
      FUNCT3_SH: begin
        be      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{data[15:0]}};
        illegal = addr_lo[0];
      end
      FUNCT3_SW: begin
        be      = 4'b1111;
        wdata   = data;
        illegal = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_commit_queue.sv
// rtl/store_commit_queue.sv - post-commit store drain FIFO
// Accepts retired stores, formats them into word writes, queues them in
// strict order and drains them to data memory. Also reports whether a load
// address shares a word with any undrained store.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   exception     pipeline flush; committed stores are unaffected
//   bus           commit and dmem handshakes (slave side)
//   snoop_addr    load address to check; snoop_hit is combinational
//   misalign_err  one-cycle pulse after an illegal commit is dropped
//   count, empty  occupancy
module store_commit_queue
  import store_commit_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       exception,
  store_commit_queue_if.slave        bus,
  input  logic [31:0]                snoop_addr,
  output logic                       snoop_hit,
  output logic                       misalign_err,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  scq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  occ;

  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_be;
  logic        fmt_illegal;

  logic       full;
  logic       accept;
  logic       push;
  logic       pop;
  scq_entry_t head;
  scq_entry_t new_entry;

  store_lane_fmt u_fmt (
    .funct3  (bus.commit_funct3),
    .addr_lo (bus.commit_addr[1:0]),
    .data    (bus.commit_data),
    .wdata   (fmt_wdata),
    .be      (fmt_be),
    .illegal (fmt_illegal)
  );

  // Ready is taken from the registered count only, so a same-cycle pop
  // never opens a slot; keeps commit_ready off the dmem_ack path.
  assign full   = (occ == CNT_W'(DEPTH));
  assign accept = bus.commit_valid && !full;
  assign push   = accept && !fmt_illegal;
  assign pop    = !empty && bus.dmem_ack;

  assign new_entry.word_addr = bus.commit_addr[31:2];
  assign new_entry.wdata     = fmt_wdata;
  assign new_entry.be        = fmt_be;
  assign new_entry.inst_num  = bus.commit_inst_num;

  // Entry storage carries no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      misalign_err <= accept && fmt_illegal;
    end
  end

  assign count = occ;
  assign empty = (occ == '0);

  assign head             = mem[rd_ptr];
  assign bus.commit_ready = !full;
  assign bus.dmem_req     = !empty;
  assign bus.dmem_addr    = {head.word_addr, 2'b00};
  assign bus.dmem_wdata   = head.wdata;
  assign bus.dmem_be      = head.be;

  // A slot is live when its distance from the head (mod DEPTH) is below
  // the occupancy; this handles wrap and the full case uniformly.
  always_comb begin
    logic [PTR_W-1:0] off;
    off       = '0;
    snoop_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr;
      if ((CNT_W'(off) < occ) && (mem[i].word_addr == snoop_addr[31:2])) begin
        snoop_hit = 1'b1;
      end
    end
  end

  // Flush and sub-word snoop bits have no effect here; inst_num is kept
  // in the entry for debug visibility only.
  logic unused_sig;
  assign unused_sig = ^{exception, snoop_addr[1:0], head.inst_num};

endmodule

// File: tb/tb_store_commit_queue.sv
// tb/tb_store_commit_queue.sv - directed self-checking bench for store_commit_queue
module tb_store_commit_queue;

  logic        clk;
  logic        reset;
  logic        exception;
  logic [31:0] snoop_addr;
  logic        snoop_hit;
  logic        misalign_err;
  logic [3:0]  count;
  logic        empty;

  int n_tests;
  int n_fail;

  store_commit_queue_if bus ();

  store_commit_queue #(.DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .exception    (exception),
    .bus          (bus),
    .snoop_addr   (snoop_addr),
    .snoop_hit    (snoop_hit),
    .misalign_err (misalign_err),
    .count        (count),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_commit(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    bus.commit_valid    = 1'b1;
    bus.commit_funct3   = f3;
    bus.commit_addr     = addr;
    bus.commit_data     = data;
    bus.commit_inst_num = bus.commit_inst_num + 1;
    @(negedge clk);
    bus.commit_valid = 1'b0;
  endtask

  task automatic drain_one();
    bus.dmem_ack = 1'b1;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } lane_vec_t;

  lane_vec_t lanes [6];
  logic [2:0]  bad_f3   [6];
  logic [31:0] bad_addr [6];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    exception = 1'b0;
    snoop_addr = 32'h0;
    bus.commit_valid = 1'b0;
    bus.commit_addr = '0;
    bus.commit_data = '0;
    bus.commit_funct3 = '0;
    bus.commit_inst_num = '0;
    bus.dmem_ack = 1'b0;

    lanes[0] = '{3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB};
    lanes[1] = '{3'b000, 32'h0000_1000, 32'h0000_005A, 32'h0000_1000, 4'b0001, 32'h5A5A_5A5A};
    lanes[2] = '{3'b000, 32'h0000_1001, 32'hFFFF_FF77, 32'h0000_1000, 4'b0010, 32'h7777_7777};
    lanes[3] = '{3'b001, 32'h0000_2000, 32'h0000_BEEF, 32'h0000_2000, 4'b0011, 32'hBEEF_BEEF};
    lanes[4] = '{3'b001, 32'h0000_2002, 32'h0000_1234, 32'h0000_2000, 4'b1100, 32'h1234_1234};
    lanes[5] = '{3'b010, 32'h0000_7008, 32'h0123_4567, 32'h0000_7008, 4'b1111, 32'h0123_4567};

    bad_f3[0] = 3'b010; bad_addr[0] = 32'h0000_4001;
    bad_f3[1] = 3'b010; bad_addr[1] = 32'h0000_4002;
    bad_f3[2] = 3'b001; bad_addr[2] = 32'h0000_4001;
    bad_f3[3] = 3'b001; bad_addr[3] = 32'h0000_4003;
    bad_f3[4] = 3'b011; bad_addr[4] = 32'h0000_4000;
    bad_f3[5] = 3'b100; bad_addr[5] = 32'h0000_4000;

    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_req", bus.dmem_req, 0);
    check("rst_ready", bus.commit_ready, 1);
    check("rst_misalign", misalign_err, 0);
    check("rst_snoop", snoop_hit, 0);

    // Ack with nothing queued must not pop.
    drain_one();
    check("ack_empty_count", count, 0);
    check("ack_empty_req", bus.dmem_req, 0);

    // Lane formatting, one store at a time.
    for (int i = 0; i < 6; i++) begin
      do_commit(lanes[i].f3, lanes[i].addr, lanes[i].data);
      check($sformatf("lane%0d_req", i), bus.dmem_req, 1);
      check($sformatf("lane%0d_addr", i), bus.dmem_addr, lanes[i].exp_addr);
      check($sformatf("lane%0d_be", i), bus.dmem_be, lanes[i].exp_be);
      check($sformatf("lane%0d_wdata", i), bus.dmem_wdata, lanes[i].exp_wdata);
      check($sformatf("lane%0d_mis", i), misalign_err, 0);
      drain_one();
      check($sformatf("lane%0d_empty", i), empty, 1);
    end

    // Stall: SH then SW with ack held low; head must stay stable.
    do_commit(3'b001, 32'h0000_2002, 32'h0000_1234);
    do_commit(3'b010, 32'h0000_3000, 32'hDEAD_BEEF);
    for (int c = 0; c < 3; c++) begin
      check("stall_addr", bus.dmem_addr, 32'h0000_2000);
      check("stall_be", bus.dmem_be, 4'b1100);
      check("stall_wdata", bus.dmem_wdata, 32'h1234_1234);
      check("stall_count", count, 2);
      @(negedge clk);
    end
    drain_one();
    check("sw_after_ack_addr", bus.dmem_addr, 32'h0000_3000);
    check("sw_after_ack_be", bus.dmem_be, 4'b1111);
    check("sw_after_ack_wdata", bus.dmem_wdata, 32'hDEAD_BEEF);
    drain_one();
    check("stall_empty", empty, 1);

    // Illegal commits are consumed and pulse misalign_err for one cycle.
    for (int i = 0; i < 6; i++) begin
      do_commit(bad_f3[i], bad_addr[i], 32'h1111_2222);
      check($sformatf("bad%0d_mis", i), misalign_err, 1);
      check($sformatf("bad%0d_count", i), count, 0);
      check($sformatf("bad%0d_req", i), bus.dmem_req, 0);
      @(negedge clk);
      check($sformatf("bad%0d_mis_clr", i), misalign_err, 0);
    end

    // Fill to DEPTH with ack low, then try a ninth.
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fill%0d_ready", i), bus.commit_ready, 1);
      do_commit(3'b010, 32'h0000_6000 + 32'(4 * i), 32'(i));
    end
    check("full_count", count, 8);
    check("full_ready", bus.commit_ready, 0);
    do_commit(3'b010, 32'h0000_9000, 32'h9);
    check("ninth_rejected", count, 8);
    // Full with a pop in the same cycle: still not accepted.
    bus.dmem_ack = 1'b1;
    do_commit(3'b010, 32'h0000_9004, 32'hA);
    check("full_pop_count", count, 7);
    check("full_pop_addr", bus.dmem_addr, 32'h0000_6004);
    for (int i = 1; i < 8; i++) begin
      check($sformatf("drain%0d_addr", i), bus.dmem_addr, 32'h0000_6000 + 32'(4 * i));
      check($sformatf("drain%0d_wdata", i), bus.dmem_wdata, 32'(i));
      @(negedge clk);
    end
    bus.dmem_ack = 1'b0;
    check("drain_empty", empty, 1);
    check("drain_req", bus.dmem_req, 0);

    // Push and pop in the same cycle keep count steady.
    do_commit(3'b010, 32'h0000_A000, 32'h1);
    bus.dmem_ack = 1'b1;
    do_commit(3'b010, 32'h0000_A004, 32'h2);
    bus.dmem_ack = 1'b0;
    check("pushpop_count", count, 1);
    check("pushpop_addr", bus.dmem_addr, 32'h0000_A004);
    drain_one();
    check("pushpop_empty", empty, 1);

    // Snoop and exception.
    do_commit(3'b010, 32'h0000_5000, 32'h5555_5555);
    snoop_addr = 32'h0000_5002;
    #1 check("snoop_hit_same_word", snoop_hit, 1);
    snoop_addr = 32'h0000_5004;
    #1 check("snoop_miss_next_word", snoop_hit, 0);
    snoop_addr = 32'h0000_5000;
    exception = 1'b1;
    @(negedge clk);
    exception = 1'b0;
    check("exc_count", count, 1);
    check("exc_addr", bus.dmem_addr, 32'h0000_5000);
    bus.dmem_ack = 1'b1;
    #1 check("snoop_hit_ack_cycle", snoop_hit, 1);
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    check("exc_drained", empty, 1);
    check("snoop_after_drain", snoop_hit, 0);

    // Reset with requests outstanding.
    do_commit(3'b010, 32'h0000_B000, 32'h1);
    do_commit(3'b010, 32'h0000_B004, 32'h2);
    do_commit(3'b010, 32'h0000_B008, 32'h3);
    check("pre_rst_count", count, 3);
    check("pre_rst_req", bus.dmem_req, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_count", count, 0);
    check("mid_rst_req", bus.dmem_req, 0);
    check("mid_rst_ready", bus.commit_ready, 1);
    do_commit(3'b000, 32'h0000_C002, 32'h0000_00C3);
    check("post_rst_addr", bus.dmem_addr, 32'h0000_C000);
    check("post_rst_be", bus.dmem_be, 4'b0100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
